clk_gate_ctrl: RTL and testbench

Controller that generates the enable for an integrated clock-gating cell in front of a gated clock domain. Requesters ask for the clock with a level request; the controller turns the clock on, waits a wake-up settle period, and acknowledges. When all requests, domain activity and the force input are idle, it waits a programmable hysteresis period before turning the clock off. It runs in the free-running (ungated) clock domain. `clk_en_o` drives the `en_i` of the downstream gating cell.

---
 rtl/clk_gate_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Generates the enable for an integrated clock-gating cell that sits in front
// of a gated clock domain. Requesters raise a level request. The controller
// turns the clock on, waits a settle period, and then acknowledges. Once
// requests, domain activity and the force input are all idle, it waits a
// programmable hysteresis period and then turns the clock off. The block runs
// in the free-running clock domain.
//
// Ports
//   clk_i          free-running clock
//   rst_ni         asynchronous active-low reset
//   req_i          per-requester level request for the gated clock
//   ack_o          per-requester acknowledge (clock running and settled)
//   busy_i         gated-domain activity flag; holds the clock on
//   force_on_i     test/debug override; keeps or turns the clock on
//   idle_thresh_i  hysteresis length, sampled when DRAIN is entered
//   clk_en_o       registered enable to the gating cell's en_i
//   state_o        current state (OFF=0, WAKE=1, ON=2, DRAIN=3)
//
// state | meaning
// ------+----------------------------------------------------------------
// OFF   | clock gated off, waiting for any need
// WAKE  | clock enabled, counting down the settle period
// ON    | clock settled, active requests acknowledged
// DRAIN | nothing needs the clock; hysteresis countdown before OFF
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CNT_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    ack_o,
    input  logic                  busy_i,
    input  logic                  force_on_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    output logic                  clk_en_o,
    output logic [1:0]            state_o
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES) + 1;
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WAKE_W-1:0]      wake_cnt_q, wake_cnt_d;
    logic [IDLE_CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic                   clk_en_q, clk_en_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   need;

    assign need = (|req_i) | busy_i | force_on_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            clk_en_q   <= 1'b0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            clk_en_q   <= clk_en_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;

        unique case (state_q)
            ST_OFF: begin
                if (need) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Need is ignored here: a wake always settles into ON.
                if (wake_cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    wake_cnt_d = wake_cnt_q - WAKE_W'(1);
                end
            end
            ST_ON: begin
                if (!need) begin
                    state_d    = ST_DRAIN;
                    idle_cnt_d = idle_thresh_i;
                end
            end
            ST_DRAIN: begin
                // Clock is still running, so a new need returns straight to ON.
                if (need) begin
                    state_d = ST_ON;
                end else if (idle_cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    idle_cnt_d = idle_cnt_q - IDLE_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        clk_en_d = (state_d != ST_OFF);
        ack_d    = (state_d == ST_ON) ? req_i : '0;
    end

    assign ack_o    = ack_q;
    assign clk_en_o = clk_en_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        busy;
    logic        force_on;
    logic [7:0]  thresh;
    logic        clk_en;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fails  = 0;

    logic watch_en;
    logic en_dropped;

    clk_gate_ctrl #(
        .NUM_REQ     (4),
        .WAKE_CYCLES (2),
        .IDLE_CNT_W  (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .ack_o         (ack),
        .busy_i        (busy),
        .force_on_i    (force_on),
        .idle_thresh_i (thresh),
        .clk_en_o      (clk_en),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch_en && !clk_en) en_dropped <= 1'b1;
    end

    typedef struct {
        logic [3:0] req;
        logic       busy;
        logic       force_on;
        logic [7:0] thresh;
        logic [1:0] st;
        logic       en;
        logic [3:0] ack;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic en, input logic [3:0] a);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " clk_en"}, 32'(clk_en), 32'(en));
        check({tag, " ack"}, 32'(ack), 32'(a));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // cold wake, second requester, hysteresis, wake with dropped request,
        // threshold change during DRAIN ignored
        tbl[0]  = '{4'b0001, 1'b0, 1'b0, 8'd0, 2'd1, 1'b1, 4'b0000};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 8'd0, 2'd1, 1'b1, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1, 4'b0001};
        tbl[3]  = '{4'b0101, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1, 4'b0101};
        tbl[4]  = '{4'b0100, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1, 4'b0100};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 8'd3, 2'd3, 1'b1, 4'b0000};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 8'd3, 2'd3, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 8'd3, 2'd3, 1'b1, 4'b0000};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 8'd3, 2'd3, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 8'd3, 2'd0, 1'b0, 4'b0000};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 8'd3, 2'd0, 1'b0, 4'b0000};
        tbl[11] = '{4'b0010, 1'b0, 1'b0, 8'd2, 2'd1, 1'b1, 4'b0000};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 8'd2, 2'd1, 1'b1, 4'b0000};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 8'd2, 2'd2, 1'b1, 4'b0000};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 8'd2, 2'd3, 1'b1, 4'b0000};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 8'd7, 2'd3, 1'b1, 4'b0000};
        tbl[16] = '{4'b0000, 1'b0, 1'b0, 8'd7, 2'd3, 1'b1, 4'b0000};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 8'd7, 2'd0, 1'b0, 4'b0000};

        watch_en   = 1'b0;
        en_dropped = 1'b0;
        rst_n      = 1'b0;
        req        = '0;
        busy       = 1'b0;
        force_on   = 1'b0;
        thresh     = '0;

        #3;
        check_outs("reset", 2'd0, 1'b0, 4'b0000);
        step(2);
        rst_n = 1'b1;
        step(1);
        check_outs("idle after reset", 2'd0, 1'b0, 4'b0000);

        for (int i = 0; i < NVEC; i++) begin
            req      = tbl[i].req;
            busy     = tbl[i].busy;
            force_on = tbl[i].force_on;
            thresh   = tbl[i].thresh;
            step(1);
            check_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].en, tbl[i].ack);
        end

        // DRAIN abort on the third DRAIN cycle
        req = 4'b0100;
        step(3);
        check_outs("abort pre", 2'd2, 1'b1, 4'b0100);
        req    = '0;
        thresh = 8'd5;
        en_dropped = 1'b0;
        watch_en   = 1'b1;
        step(3);
        check_outs("abort drain3", 2'd3, 1'b1, 4'b0000);
        req = 4'b0100;
        step(1);
        check_outs("abort on", 2'd2, 1'b1, 4'b0100);
        watch_en = 1'b0;
        check("abort en held", 32'(en_dropped), 32'd0);

        // DRAIN with counter at zero and need at the same edge: ON wins
        req    = '0;
        thresh = 8'd0;
        step(1);
        check_outs("zero drain", 2'd3, 1'b1, 4'b0000);
        req = 4'b0010;
        step(1);
        check_outs("on wins", 2'd2, 1'b1, 4'b0010);

        // busy holds ON indefinitely
        req  = '0;
        busy = 1'b1;
        step(20);
        check_outs("busy hold", 2'd2, 1'b1, 4'b0000);
        busy   = 1'b0;
        thresh = 8'd1;
        step(1);
        check_outs("busy drop", 2'd3, 1'b1, 4'b0000);
        step(2);
        check_outs("busy off", 2'd0, 1'b0, 4'b0000);

        // force from OFF: wake then ON with no acks; thresh 0 -> OFF in 2 edges
        force_on = 1'b1;
        step(1);
        check_outs("force wake", 2'd1, 1'b1, 4'b0000);
        step(2);
        check_outs("force on", 2'd2, 1'b1, 4'b0000);
        force_on = 1'b0;
        thresh   = 8'd0;
        step(1);
        check_outs("t0 drain", 2'd3, 1'b1, 4'b0000);
        step(1);
        check_outs("t0 off", 2'd0, 1'b0, 4'b0000);

        // asynchronous reset in the middle of ON
        req = 4'b0011;
        step(3);
        check_outs("pre reset", 2'd2, 1'b1, 4'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async reset", 2'd0, 1'b0, 4'b0000);
        req = '0;
        step(1);
        rst_n = 1'b1;
        step(3);
        check_outs("post reset", 2'd0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
